// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
//   Shared definitions for the LED sweep sequencer:
//     - phase_t      : 3-bit phase encoding reported on the phase output
//     - SEL_*        : 2-bit encoding of the manual mode_sel input
//     - sel_to_phase : maps a mode_sel value to the phase it selects
//     - start_pattern: first LED pattern of a phase for a bank of width w
//                      (returned MAX_W wide; callers truncate to their width)
// ---------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_L2R  = 3'd1,
        PH_R2L  = 3'd2,
        PH_M2S  = 3'd3,
        PH_S2M  = 3'd4
    } phase_t;

    localparam logic [1:0] SEL_L2R = 2'd0;
    localparam logic [1:0] SEL_R2L = 2'd1;
    localparam logic [1:0] SEL_M2S = 2'd2;
    localparam logic [1:0] SEL_S2M = 2'd3;

    localparam int MAX_W = 64;

    function automatic phase_t sel_to_phase(input logic [1:0] sel);
        phase_t ph;
        case (sel)
            SEL_L2R: ph = PH_L2R;
            SEL_R2L: ph = PH_R2L;
            SEL_M2S: ph = PH_M2S;
            SEL_S2M: ph = PH_S2M;
            default: ph = PH_L2R;
        endcase
        return ph;
    endfunction

    function automatic logic [MAX_W-1:0] start_pattern(input phase_t ph, input int unsigned w);
        logic [MAX_W-1:0] one;
        logic [MAX_W-1:0] pat;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        case (ph)
            PH_L2R:  pat = one << (w - 1);
            PH_R2L:  pat = one;
            PH_M2S:  pat = (one << (w / 2)) | (one << (w / 2 - 1));
            PH_S2M:  pat = (one << (w - 1)) | one;
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
//   Prescaler for the sweep sequencer. Counts 0..TICK_DIV-1 on enabled
//   cycles and raises a registered one-cycle tick on every wrap, so the first
//   tick after a cleared count appears TICK_DIV enabled cycles later.
//   Ports:
//     clk   in   system clock
//     rst_n in   asynchronous active-low reset
//     en    in   count enable; low holds the count and suppresses tick
//     clr   in   synchronous clear of count and tick (dominates en)
//     tick  out  one-cycle step strobe
// ---------------------------------------------------------------------------
module led_tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_sweep_seq.sv
// ---------------------------------------------------------------------------
// led_sweep_seq
//   LED sweep sequencer. Steps a one-hot (L2R, R2L) or two-hot (M2S, S2M)
//   pattern across an LED_W-wide bank, one step per prescaler tick. Phases
//   rotate automatically or follow mode_sel, chosen on each phase's ending
//   tick; the ending tick loads the next phase's start pattern directly.
//   Optional build macro LED_SEQ_PWM_EN adds a 16-level brightness gate
//   driven by the duty input.
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     en         in   run enable; low freezes the sequence
//     clr        in   synchronous return to IDLE (dominates en and tick)
//     mode_auto  in   1 = rotate L2R->R2L->M2S->S2M, 0 = follow mode_sel
//     mode_sel   in   manual next phase: 0 L2R, 1 R2L, 2 M2S, 3 S2M
//     duty       in   PWM duty 0..15 (LED_SEQ_PWM_EN builds only)
//     led        out  LED drive, active high
//     phase      out  current phase: 0 IDLE, 1 L2R, 2 R2L, 3 M2S, 4 S2M
//     cycle_done out  one-cycle pulse on the auto-mode S2M->L2R transition
// ---------------------------------------------------------------------------
module led_sweep_seq
    import led_seq_pkg::*;
#(
    parameter int LED_W    = 16,
    parameter int TICK_DIV = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             mode_auto,
    input  logic [1:0]       mode_sel,
`ifdef LED_SEQ_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [LED_W-1:0] led,
    output logic [2:0]       phase,
    output logic             cycle_done
);

    localparam int H = LED_W / 2;

    logic             tick;
    phase_t           ph_q, ph_d, ph_nx;
    logic [LED_W-1:0] pat_q, pat_d, pat_start;
    logic             cd_q, cd_d;
    logic [H-1:0]     up, lo;
    logic             phase_end;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .tick  (tick)
    );

    // Phase that follows the current one if it ends on this tick. From IDLE
    // in auto mode the default branch yields L2R.
    always_comb begin
        ph_nx = PH_L2R;
        if (mode_auto) begin
            case (ph_q)
                PH_L2R:  ph_nx = PH_R2L;
                PH_R2L:  ph_nx = PH_M2S;
                PH_M2S:  ph_nx = PH_S2M;
                default: ph_nx = PH_L2R;
            endcase
        end else begin
            ph_nx = sel_to_phase(mode_sel);
        end
    end

    assign pat_start = LED_W'(start_pattern(ph_nx, LED_W));

    // Step logic: the pattern register is split into an upper and lower half
    // so the two-hot phases move each bit within its own half.
    always_comb begin
        ph_d      = ph_q;
        pat_d     = pat_q;
        cd_d      = 1'b0;
        phase_end = 1'b0;
        up        = pat_q[LED_W-1:H];
        lo        = pat_q[H-1:0];

        if (clr) begin
            ph_d  = PH_IDLE;
            pat_d = '0;
        end else if (tick) begin
            case (ph_q)
                PH_L2R: begin
                    if (pat_q[0]) phase_end = 1'b1;
                    else          pat_d = pat_q >> 1;
                end
                PH_R2L: begin
                    if (pat_q[LED_W-1]) phase_end = 1'b1;
                    else                pat_d = pat_q << 1;
                end
                PH_M2S: begin
                    if (pat_q[LED_W-1] && pat_q[0]) phase_end = 1'b1;
                    else                            pat_d = {up << 1, lo >> 1};
                end
                PH_S2M: begin
                    if (pat_q[H] && pat_q[H-1]) phase_end = 1'b1;
                    else                        pat_d = {up >> 1, lo << 1};
                end
                default: phase_end = 1'b1;
            endcase

            if (phase_end) begin
                ph_d  = ph_nx;
                pat_d = pat_start;
                cd_d  = mode_auto && (ph_q == PH_S2M);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= PH_IDLE;
            pat_q <= '0;
            cd_q  <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            pat_q <= pat_d;
            cd_q  <= cd_d;
        end
    end

    assign phase      = ph_q;
    assign cycle_done = cd_q;

`ifdef LED_SEQ_PWM_EN
    // Free-running 16-step brightness counter; LEDs are lit while p < duty.
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= 4'd0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign led = pat_q & {LED_W{pwm_cnt < duty}};
`else
    assign led = pat_q;
`endif

endmodule
